mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
- Memory controller that sits directly downstream of the load/store buffer and the instruction fetch unit.
- Arbitrates their requests onto the single byte-wide RAM port: serialises 1/2/4-byte loads and stores, and 4-byte instruction fetches.
- Assembles and sign/zero-extends load data, then returns a one-cycle completion pulse to the requester.

Parameters:
- ADDR_W, 32, width of memory address.
- IO_HI, 2'b11, value of addr[17:16] that marks the I/O region.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  asynchronous, active-low reset.
- rdy  in  1  global enable; when low all state freezes.
- rollback  in  1  pipeline flush; aborts an in-flight or pending fetch only.
- io_buffer_full  in  1  UART buffer full; blocks I/O-region stores.
- lsb_in_config  in  1  LSB request valid (level, held until completion).
- lsb_in_ls  in  1  1 = load, 0 = store.
- lsb_in_addr  in  32  byte address.
- lsb_in_data  in  32  store data (low bytes used).
- lsb_in_precise  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- lsb_out_config  out  1  one-cycle completion pulse to LSB.
- lsb_out_data  out  32  extended load result (0 for stores).
- if_in_config  in  1  fetch request valid (level).
- if_in_addr  in  32  fetch address.
- if_out_config  out  1  one-cycle fetch completion pulse.
- if_out_inst  out  32  fetched word, little-endian.
- mem_din  in  8  RAM read byte; valid one cycle after mem_a.
- mem_dout  out  8  RAM write byte.
- mem_a  out  32  RAM byte address.
- mem_wr  out  1  1 = write this cycle.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, byte counter=0.
  - mem_a=0, mem_dout=0, mem_wr=0.
  - lsb_out_config=0, lsb_out_data=0, if_out_config=0, if_out_inst=0.
- States: IDLE, LOAD, STORE, FETCH, COOL.
- Length n: 1 for precise[1:0]=00, 2 for 01, 4 for 10. Fetch is always n=4.
- IDLE:
  - lsb_in_config has priority over if_in_config.
  - On accept edge E0: latch addr, data, precise, and n; drive mem_a=addr; counter=0.
- Deferred store: a store with addr[17:16]==IO_HI while io_buffer_full=1 is not accepted. A pending fetch may be accepted instead.
- LOAD / FETCH, edge Ek (k=1..n):
  - Capture mem_din into byte k-1.
  - If k<n, drive mem_a=addr+k.
  - At En: pulse the requester's out_config=1 with the assembled data.
- Load extension: B/H sign-extend from bit 7/15; BU/HU zero-extend.
- STORE:
  - E0: mem_wr=1, mem_dout=data[7:0], mem_a=addr.
  - Ek (k<n): mem_dout=data[8k+7:8k], mem_a=addr+k.
  - En: mem_wr=0, lsb_out_config=1, lsb_out_data=0.
- Latency: completion pulse appears n cycles after the accept edge. Word load, store, or fetch = 4 cycles.
- COOL:
  - Entered after every completion; lasts exactly one cycle, with no accept.
  - Purpose: the LSB and fetch unit drop their level requests one edge after the pulse, and this prevents re-accepting the same request.
  - Then IDLE.
- out_config pulses are cleared on the next enabled edge.
- Rollback=1:
  - During FETCH: abort at that edge, no if_out_config, mem_a unchanged, go to COOL.
  - In IDLE: a fetch is not accepted that cycle; LSB requests are still accepted.
  - LOAD/STORE always run to completion, since the LSB consumes the response even during rollback.
- rdy=0: all registers hold, except mem_wr forced to 0 so no duplicate write occurs. Resume exactly where paused.
- Address arithmetic wraps modulo 2^32.
- Reset mid-operation aborts immediately; a partial store is not undone.

Test Plan:
- LW, addr 0x100, RAM bytes 0x78,0x56,0x34,0x12 → lsb_out_config pulses 4 cycles after accept; lsb_out_data=0x12345678; mem_a sequence 0x100..0x103.
- LB, addr 0x200 holding 0x80, then LBU same addr → data 0xFFFFFF80, then 0x00000080; each completes 1 cycle after accept; 1 COOL cycle between them.
- SH, addr 0x300, data 0xAABBCCDD → mem_wr=1 for 2 cycles writing 0xDD@0x300, 0xCC@0x301; then mem_wr=0 and lsb_out_config=1.
- LSB load and fetch requested same cycle → load served first; fetch accepted after COOL; if_out_inst correct.
- Fetch in progress, rollback at cycle 2 → no if_out_config, state COOL then IDLE. Repeat with a store in progress and rollback → store completes with all 4 bytes written.
- SB to 0x30000 with io_buffer_full=1 for 3 cycles → no mem_wr while full; accept on first cycle full=0. Separately, rdy=0 mid-load → outputs held, final data correct.

Source files
------------

// File: rtl/mem_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mem_ctrl                                                        |
// | Brief    : Arbitrates LSB loads/stores and instruction fetches onto a      |
// |            byte-wide RAM port and returns one-cycle completion pulses.     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module mem_ctrl #(
    parameter int         ADDR_W = 32,
    parameter logic [1:0] IO_HI  = 2'b11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              rollback,
    input  logic              io_buffer_full,
    input  logic              lsb_in_config,
    input  logic              lsb_in_ls,
    input  logic [ADDR_W-1:0] lsb_in_addr,
    input  logic [31:0]       lsb_in_data,
    input  logic [2:0]        lsb_in_precise,
    output logic              lsb_out_config,
    output logic [31:0]       lsb_out_data,
    input  logic              if_in_config,
    input  logic [ADDR_W-1:0] if_in_addr,
    output logic              if_out_config,
    output logic [31:0]       if_out_inst,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        STORE = 3'd2,
        FETCH = 3'd3,
        COOL  = 3'd4
    } state_t;

    localparam logic [2:0] c_FETCH_LEN = 3'd4;

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [2:0]        len_q, len_d;
    logic [2:0]        prec_q, prec_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic [31:0]       buf_q, buf_d;
    logic [ADDR_W-1:0] mem_a_q, mem_a_d;
    logic [7:0]        mem_dout_q, mem_dout_d;
    logic              mem_wr_q, mem_wr_d;
    logic              lsb_out_config_q, lsb_out_config_d;
    logic [31:0]       lsb_out_data_q, lsb_out_data_d;
    logic              if_out_config_q, if_out_config_d;
    logic [31:0]       if_out_inst_q, if_out_inst_d;

    logic [2:0]        w_cnt_nx;
    logic              w_more;
    logic              w_blocked;
    logic [ADDR_W-1:0] w_next_a;
    logic [31:0]       w_asm;

    function automatic logic [2:0] len_of(input logic [1:0] p);
        case (p)
            2'b00:   len_of = 3'd1;
            2'b01:   len_of = 3'd2;
            default: len_of = 3'd4;
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [2:0] p, input logic [31:0] w);
        case (p)
            3'b000:  extend = {{24{w[7]}}, w[7:0]};
            3'b001:  extend = {{16{w[15]}}, w[15:0]};
            3'b100:  extend = {24'h0, w[7:0]};
            3'b101:  extend = {16'h0, w[15:0]};
            default: extend = w;
        endcase
    endfunction

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        len_d            = len_q;
        prec_d           = prec_q;
        addr_d           = addr_q;
        data_d           = data_q;
        buf_d            = buf_q;
        mem_a_d          = mem_a_q;
        mem_dout_d       = mem_dout_q;
        mem_wr_d         = mem_wr_q;
        lsb_out_config_d = 1'b0;
        lsb_out_data_d   = lsb_out_data_q;
        if_out_config_d  = 1'b0;
        if_out_inst_d    = if_out_inst_q;

        w_cnt_nx  = cnt_q + 3'd1;
        w_more    = (w_cnt_nx < len_q);
        w_next_a  = addr_q + ADDR_W'(w_cnt_nx);
        w_asm     = buf_q;
        w_asm[{cnt_q[1:0], 3'b000} +: 8] = mem_din;
        // Stores to the UART window wait while its buffer is full.
        w_blocked = !lsb_in_ls && (lsb_in_addr[17:16] == IO_HI) && io_buffer_full;

        case (state_q)
            IDLE: begin
                if (lsb_in_config && !w_blocked) begin
                    addr_d  = lsb_in_addr;
                    data_d  = lsb_in_data;
                    prec_d  = lsb_in_precise;
                    len_d   = len_of(lsb_in_precise[1:0]);
                    cnt_d   = 3'd0;
                    buf_d   = 32'h0;
                    mem_a_d = lsb_in_addr;
                    if (lsb_in_ls) begin
                        state_d = LOAD;
                    end else begin
                        state_d    = STORE;
                        mem_wr_d   = 1'b1;
                        mem_dout_d = lsb_in_data[7:0];
                    end
                end else if (if_in_config && !rollback) begin
                    state_d = FETCH;
                    addr_d  = if_in_addr;
                    len_d   = c_FETCH_LEN;
                    cnt_d   = 3'd0;
                    buf_d   = 32'h0;
                    mem_a_d = if_in_addr;
                end
            end
            LOAD, FETCH: begin
                if (state_q == FETCH && rollback) begin
                    state_d = COOL;
                end else begin
                    buf_d = w_asm;
                    if (w_more) begin
                        cnt_d   = w_cnt_nx;
                        mem_a_d = w_next_a;
                    end else begin
                        state_d = COOL;
                        if (state_q == LOAD) begin
                            lsb_out_config_d = 1'b1;
                            lsb_out_data_d   = extend(prec_q, w_asm);
                        end else begin
                            if_out_config_d = 1'b1;
                            if_out_inst_d   = w_asm;
                        end
                    end
                end
            end
            STORE: begin
                if (w_more) begin
                    cnt_d      = w_cnt_nx;
                    mem_a_d    = w_next_a;
                    mem_dout_d = data_q[{w_cnt_nx[1:0], 3'b000} +: 8];
                end else begin
                    state_d          = COOL;
                    mem_wr_d         = 1'b0;
                    lsb_out_config_d = 1'b1;
                    lsb_out_data_d   = 32'h0;
                end
            end
            COOL:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= IDLE;
            cnt_q            <= 3'd0;
            len_q            <= 3'd0;
            prec_q           <= 3'd0;
            addr_q           <= '0;
            data_q           <= 32'h0;
            buf_q            <= 32'h0;
            mem_a_q          <= '0;
            mem_dout_q       <= 8'h0;
            mem_wr_q         <= 1'b0;
            lsb_out_config_q <= 1'b0;
            lsb_out_data_q   <= 32'h0;
            if_out_config_q  <= 1'b0;
            if_out_inst_q    <= 32'h0;
        end else if (rdy) begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            len_q            <= len_d;
            prec_q           <= prec_d;
            addr_q           <= addr_d;
            data_q           <= data_d;
            buf_q            <= buf_d;
            mem_a_q          <= mem_a_d;
            mem_dout_q       <= mem_dout_d;
            mem_wr_q         <= mem_wr_d;
            lsb_out_config_q <= lsb_out_config_d;
            lsb_out_data_q   <= lsb_out_data_d;
            if_out_config_q  <= if_out_config_d;
            if_out_inst_q    <= if_out_inst_d;
        end
    end

    // The pending write stays registered while paused so it is issued once on resume.
    assign mem_wr         = mem_wr_q & rdy;
    assign mem_a          = mem_a_q;
    assign mem_dout       = mem_dout_q;
    assign lsb_out_config = lsb_out_config_q;
    assign lsb_out_data   = lsb_out_data_q;
    assign if_out_config  = if_out_config_q;
    assign if_out_inst    = if_out_inst_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_mem_ctrl                                                     |
// | Brief    : Scoreboard bench for mem_ctrl with a byte-wide RAM model.       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst, rdy, rollback, io_buffer_full;
    logic        lsb_in_config, lsb_in_ls;
    logic [31:0] lsb_in_addr, lsb_in_data;
    logic [2:0]  lsb_in_precise;
    logic        lsb_out_config;
    logic [31:0] lsb_out_data;
    logic        if_in_config;
    logic [31:0] if_in_addr;
    logic        if_out_config;
    logic [31:0] if_out_inst;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct { logic [31:0] data; int due; } exp_t;
    typedef struct { logic [31:0] a; logic [7:0] d; int due; } wr_t;
    exp_t lsb_q[$];
    exp_t if_q[$];
    wr_t  wr_q[$];
    exp_t le, fe;
    wr_t  we;

    logic [7:0] ram [0:4095];

    mem_ctrl #(.ADDR_W(32), .IO_HI(2'b11)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .io_buffer_full(io_buffer_full),
        .lsb_in_config(lsb_in_config), .lsb_in_ls(lsb_in_ls),
        .lsb_in_addr(lsb_in_addr), .lsb_in_data(lsb_in_data),
        .lsb_in_precise(lsb_in_precise),
        .lsb_out_config(lsb_out_config), .lsb_out_data(lsb_out_data),
        .if_in_config(if_in_config), .if_in_addr(if_in_addr),
        .if_out_config(if_out_config), .if_out_inst(if_out_inst),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
    assign mem_din = ram[mem_a[11:0]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every pulse and every write must match the head of its queue.
    always @(negedge clk) begin
        if (rst) begin
            if (lsb_out_config) begin
                if (lsb_q.size() == 0) begin
                    n_vec++; n_bad++;
                    $display("FAIL lsb_spurious: got pulse data 0x%08h, expected no pulse", lsb_out_data);
                end else begin
                    le = lsb_q.pop_front();
                    check("lsb_data", lsb_out_data, le.data);
                    check("lsb_cycle", cyc, le.due);
                end
            end
            if (if_out_config) begin
                if (if_q.size() == 0) begin
                    n_vec++; n_bad++;
                    $display("FAIL if_spurious: got pulse inst 0x%08h, expected no pulse", if_out_inst);
                end else begin
                    fe = if_q.pop_front();
                    check("if_inst", if_out_inst, fe.data);
                    check("if_cycle", cyc, fe.due);
                end
            end
            if (mem_wr) begin
                if (wr_q.size() == 0) begin
                    n_vec++; n_bad++;
                    $display("FAIL wr_spurious: got write 0x%02h at 0x%08h, expected none", mem_dout, mem_a);
                end else begin
                    we = wr_q.pop_front();
                    check("wr_addr", mem_a, we.a);
                    check("wr_byte", {24'h0, mem_dout}, {24'h0, we.d});
                    check("wr_cycle", cyc, we.due);
                end
            end
        end
    end

    // Issued just after a rising edge; accepted delay+1 edges later, paused hold edges after E1.
    task automatic lsb_req(input logic ls, input logic [31:0] addr, input logic [31:0] data,
                           input logic [2:0] prec, input logic [31:0] exp, input int delay, input int hold);
        int n, e;
        bit seen;
        n = (prec[1:0] == 2'b00) ? 1 : (prec[1:0] == 2'b01) ? 2 : 4;
        e = cyc + 1 + delay;
        lsb_in_config = 1'b1; lsb_in_ls = ls; lsb_in_addr = addr;
        lsb_in_data = data;   lsb_in_precise = prec;
        lsb_q.push_back('{exp, e + n + hold});
        if (!ls)
            for (int k = 0; k < n; k++)
                wr_q.push_back('{addr + 32'(k), data[8*k +: 8], (k == 0) ? e : e + k + hold});
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            seen = lsb_out_config;
        end
        if (!seen) begin
            n_vec++; n_bad++;
            $display("FAIL lsb_timeout: got no pulse for addr 0x%08h, expected 0x%08h", addr, exp);
        end
        @(posedge clk); #1;
        lsb_in_config = 1'b0;
    endtask

    task automatic if_req(input logic [31:0] addr, input logic [31:0] exp, input int delay);
        bit seen;
        if_in_config = 1'b1; if_in_addr = addr;
        if_q.push_back('{exp, cyc + 1 + delay + 4});
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            seen = if_out_config;
        end
        if (!seen) begin
            n_vec++; n_bad++;
            $display("FAIL if_timeout: got no pulse for addr 0x%08h, expected 0x%08h", addr, exp);
        end
        @(posedge clk); #1;
        if_in_config = 1'b0;
    endtask

    task automatic rdy_pause(input int hold, input logic [31:0] a_exp);
        repeat (2) @(posedge clk);
        #1 rdy = 1'b0;
        repeat (hold) begin
            @(negedge clk);
            check("hold_mem_a", mem_a, a_exp);
            @(posedge clk);
        end
        #1 rdy = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
        {ram[12'h100], ram[12'h101], ram[12'h102], ram[12'h103]} = {8'h78, 8'h56, 8'h34, 8'h12};
        ram[12'h200] = 8'h80;
        {ram[12'h400], ram[12'h401], ram[12'h402], ram[12'h403]} = {8'h13, 8'h05, 8'h10, 8'h00};
        {ram[12'h600], ram[12'h601], ram[12'h602], ram[12'h603]} = {8'hEF, 8'hBE, 8'hAD, 8'hDE};
        {ram[12'hFFE], ram[12'hFFF], ram[12'h000], ram[12'h001]} = {8'h01, 8'h02, 8'h03, 8'h04};

        rst = 1'b1; rdy = 1'b1; rollback = 1'b0; io_buffer_full = 1'b0;
        lsb_in_config = 1'b0; lsb_in_ls = 1'b0; lsb_in_addr = 32'h0;
        lsb_in_data = 32'h0; lsb_in_precise = 3'b000;
        if_in_config = 1'b0; if_in_addr = 32'h0;
        #1 rst = 1'b0;
        #1;
        check("rst_lsb_cfg", {31'h0, lsb_out_config}, 32'h0);
        check("rst_lsb_data", lsb_out_data, 32'h0);
        check("rst_if_cfg", {31'h0, if_out_config}, 32'h0);
        check("rst_if_inst", if_out_inst, 32'h0);
        check("rst_mem_a", mem_a, 32'h0);
        check("rst_mem_dout", {24'h0, mem_dout}, 32'h0);
        check("rst_mem_wr", {31'h0, mem_wr}, 32'h0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;

        fork
            lsb_req(1'b1, 32'h100, 32'h0, 3'b010, 32'h12345678, 0, 0);
            begin
                @(negedge clk);
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    check("lw_mem_a", mem_a, 32'h100 + 32'(k));
                end
            end
        join

        lsb_req(1'b1, 32'h200, 32'h0, 3'b000, 32'hFFFFFF80, 0, 0);
        lsb_req(1'b1, 32'h200, 32'h0, 3'b100, 32'h00000080, 0, 0);
        lsb_req(1'b1, 32'h600, 32'h0, 3'b001, 32'hFFFFBEEF, 0, 0);
        lsb_req(1'b1, 32'h600, 32'h0, 3'b101, 32'h0000BEEF, 0, 0);
        lsb_req(1'b1, 32'hFFFFFFFE, 32'h0, 3'b010, 32'h04030201, 0, 0);

        lsb_req(1'b0, 32'h300, 32'hAABBCCDD, 3'b001, 32'h0, 0, 0);

        fork
            lsb_req(1'b1, 32'h100, 32'h0, 3'b010, 32'h12345678, 0, 0);
            if_req(32'h400, 32'h00100513, 6);
        join

        // Fetch aborted by rollback at its second edge; the load after it waits out COOL.
        if_in_config = 1'b1; if_in_addr = 32'h400;
        @(posedge clk); @(posedge clk); #1;
        rollback = 1'b1; if_in_config = 1'b0;
        @(posedge clk); #1;
        rollback = 1'b0;
        lsb_req(1'b1, 32'h200, 32'h0, 3'b000, 32'hFFFFFF80, 1, 0);

        rollback = 1'b1;
        fork
            if_req(32'h400, 32'h00100513, 1);
            begin @(posedge clk); #1 rollback = 1'b0; end
        join

        rollback = 1'b1;
        lsb_req(1'b0, 32'h500, 32'h11223344, 3'b010, 32'h0, 0, 0);
        rollback = 1'b0;
        lsb_req(1'b1, 32'h500, 32'h0, 3'b010, 32'h11223344, 0, 0);

        fork
            lsb_req(1'b1, 32'h600, 32'h0, 3'b010, 32'hDEADBEEF, 0, 3);
            rdy_pause(3, 32'h601);
        join
        fork
            lsb_req(1'b0, 32'h700, 32'h0A0B0C0D, 3'b010, 32'h0, 0, 2);
            rdy_pause(2, 32'h701);
        join
        lsb_req(1'b1, 32'h700, 32'h0, 3'b010, 32'h0A0B0C0D, 0, 0);

        io_buffer_full = 1'b1;
        lsb_req(1'b0, 32'h20000, 32'hA5, 3'b000, 32'h0, 0, 0);
        fork
            lsb_req(1'b0, 32'h30000, 32'h5A, 3'b000, 32'h0, 3, 0);
            begin repeat (3) @(posedge clk); #1 io_buffer_full = 1'b0; end
        join

        io_buffer_full = 1'b1;
        fork
            lsb_req(1'b0, 32'h30004, 32'h77, 3'b000, 32'h0, 7, 0);
            if_req(32'h400, 32'h00100513, 0);
            begin repeat (7) @(posedge clk); #1 io_buffer_full = 1'b0; end
        join

        repeat (5) @(posedge clk);
        check("lsb_q_drained", lsb_q.size(), 32'h0);
        check("if_q_drained", if_q.size(), 32'h0);
        check("wr_q_drained", wr_q.size(), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
